// File: rtl/freq_seg_encode_if.sv
// Request/result bundle between the frequency source and the segment encoder.
interface freq_seg_encode_if #(
  parameter int BIN_W = 24
);
  logic [BIN_W-1:0] freq_bin;
  logic             start;
  logic             busy;
  logic             done;
  logic [27:0]      seg_value;
  logic             range_khz;
  logic             ovf;

  modport master (
    output freq_bin, start,
    input  busy, done, seg_value, range_khz, ovf
  );

  modport slave (
    input  freq_bin, start,
    output busy, done, seg_value, range_khz, ovf
  );
endinterface

// File: rtl/freq_seg_encode.sv
// Binary Hz -> four 7-segment digits with Hz/kHz auto-range and leading-zero blanking.
// Latency: 25 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is ignored while busy; results hold until the next done.
module freq_seg_encode #(
  parameter int BIN_W    = 24,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  freq_seg_encode_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, RANGE} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [31:0]      bcd;
  logic [30:0]      bcd_adj;
  logic [4:0]       cnt;
  logic [15:0]      disp;
  logic [27:0]      seg_nxt;
  logic             range_nxt;
  logic             ovf_nxt;
  logic [27:0]      seg_q;
  logic             range_q;
  logic             ovf_q;
  logic             done_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Add-3 correction; the top nibble's MSB is shifted out, so only 3 bits are kept.
  always_comb begin
    bcd_adj = bcd[30:0];
    for (int i = 0; i < 7; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    if (bcd[31:28] >= 4'd5) bcd_adj[30:28] = bcd[30:28] + 3'd3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd0) state_nxt = RANGE;
      RANGE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : range_sel
    logic blank;
    disp      = bcd[15:0];
    range_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    if (bcd[31:28] != 4'd0) begin
      disp      = 16'h9999;
      range_nxt = 1'b1;
      ovf_nxt   = 1'b1;
    end else if (bcd[27:16] != 12'd0) begin
      disp      = bcd[27:12];
      range_nxt = 1'b1;
    end
    seg_nxt = '0;
    blank   = BLANK_LZ;
    for (int i = 3; i >= 1; i--) begin
      if (blank && disp[4*i +: 4] == 4'd0) begin
        seg_nxt[7*i +: 7] = 7'h00;
      end else begin
        seg_nxt[7*i +: 7] = seg7(disp[4*i +: 4]);
        blank = 1'b0;
      end
    end
    seg_nxt[6:0] = seg7(disp[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      bin_sr  <= '0;
      bcd     <= '0;
      seg_q   <= '0;
      range_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr <= bus.freq_bin;
            bcd    <= '0;
            cnt    <= 5'(BIN_W - 1);
          end
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr, 1'b0};
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        RANGE: begin
          seg_q   <= seg_nxt;
          range_q <= range_nxt;
          ovf_q   <= ovf_nxt;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.seg_value = seg_q;
  assign bus.range_khz = range_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_freq_seg_encode.sv
// Directed bench: one blanking and one non-blanking encoder driven in lockstep.
module tb_freq_seg_encode;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  freq_seg_encode_if #(.BIN_W(24)) ifa ();
  freq_seg_encode_if #(.BIN_W(24)) ifb ();

  freq_seg_encode #(.BIN_W(24), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  freq_seg_encode #(.BIN_W(24), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  function automatic logic [27:0] pk(input logic [6:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic drive_start(input logic [23:0] v);
    @(negedge clk);
    ifa.freq_bin = v; ifb.freq_bin = v;
    ifa.start = 1'b1; ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic convert(input logic [23:0] v, output int lat, output logic busy0);
    drive_start(v);
    busy0 = ifa.busy;
    wait_done(lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.freq_bin = '0; ifb.freq_bin = '0;
    repeat (3) @(negedge clk);
    n_tot++;
    if ({ifa.seg_value, ifa.busy, ifa.done, ifa.range_khz, ifa.ovf} !== 32'h0)
      $display("FAIL reset_state got seg=%h busy=%b done=%b rng=%b ovf=%b want all 0",
               ifa.seg_value, ifa.busy, ifa.done, ifa.range_khz, ifa.ovf);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_hz;
    int lat; logic b0;
    convert(24'd1234, lat, b0);
    n_tot++;
    if (b0 !== 1'b1) $display("FAIL hz_busy_after_start got %b want 1", b0); else n_pass++;
    n_tot++;
    if (lat != 25) $display("FAIL hz_latency got %0d want 25", lat); else n_pass++;
    n_tot++;
    if (ifa.seg_value !== pk(7'h30, 7'h6D, 7'h79, 7'h33))
      $display("FAIL hz_seg got %h want %h", ifa.seg_value, pk(7'h30, 7'h6D, 7'h79, 7'h33));
    else n_pass++;
    n_tot++;
    if ({ifa.range_khz, ifa.ovf, ifa.busy} !== 3'b000)
      $display("FAIL hz_flags got rng/ovf/busy=%b%b%b want 000", ifa.range_khz, ifa.ovf, ifa.busy);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (ifa.done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", ifa.done); else n_pass++;
  endtask

  task automatic test_blanking;
    int lat; logic b0;
    convert(24'd7, lat, b0);
    n_tot++;
    if (ifa.seg_value !== pk(7'h00, 7'h00, 7'h00, 7'h70))
      $display("FAIL blank_7 got %h want %h", ifa.seg_value, pk(7'h00, 7'h00, 7'h00, 7'h70));
    else n_pass++;
    n_tot++;
    if (ifb.seg_value !== pk(7'h7E, 7'h7E, 7'h7E, 7'h70))
      $display("FAIL noblank_7 got %h want %h", ifb.seg_value, pk(7'h7E, 7'h7E, 7'h7E, 7'h70));
    else n_pass++;
    convert(24'd0, lat, b0);
    n_tot++;
    if (ifa.seg_value !== pk(7'h00, 7'h00, 7'h00, 7'h7E))
      $display("FAIL blank_0 got %h want %h", ifa.seg_value, pk(7'h00, 7'h00, 7'h00, 7'h7E));
    else n_pass++;
    n_tot++;
    if (ifb.seg_value !== pk(7'h7E, 7'h7E, 7'h7E, 7'h7E))
      $display("FAIL noblank_0 got %h want %h", ifb.seg_value, pk(7'h7E, 7'h7E, 7'h7E, 7'h7E));
    else n_pass++;
  endtask

  task automatic test_khz;
    int lat; logic b0;
    convert(24'd12345, lat, b0);
    n_tot++;
    if ({ifa.seg_value, ifa.range_khz, ifa.ovf} !== {pk(7'h00, 7'h00, 7'h30, 7'h6D), 2'b10})
      $display("FAIL khz_12345 got seg=%h rng=%b ovf=%b want seg=%h rng=1 ovf=0",
               ifa.seg_value, ifa.range_khz, ifa.ovf, pk(7'h00, 7'h00, 7'h30, 7'h6D));
    else n_pass++;
    convert(24'd9999999, lat, b0);
    n_tot++;
    if ({ifa.seg_value, ifa.range_khz, ifa.ovf} !== {pk(7'h7B, 7'h7B, 7'h7B, 7'h7B), 2'b10})
      $display("FAIL khz_max got seg=%h rng=%b ovf=%b want seg=%h rng=1 ovf=0",
               ifa.seg_value, ifa.range_khz, ifa.ovf, pk(7'h7B, 7'h7B, 7'h7B, 7'h7B));
    else n_pass++;
    convert(24'd10000, lat, b0);
    n_tot++;
    if ({ifa.seg_value, ifa.range_khz, ifa.ovf} !== {pk(7'h00, 7'h00, 7'h30, 7'h7E), 2'b10})
      $display("FAIL khz_10000 got seg=%h rng=%b ovf=%b want seg=%h rng=1 ovf=0",
               ifa.seg_value, ifa.range_khz, ifa.ovf, pk(7'h00, 7'h00, 7'h30, 7'h7E));
    else n_pass++;
    n_tot++;
    if (ifb.seg_value !== pk(7'h7E, 7'h7E, 7'h30, 7'h7E))
      $display("FAIL khz_10000_noblank got %h want %h", ifb.seg_value, pk(7'h7E, 7'h7E, 7'h30, 7'h7E));
    else n_pass++;
  endtask

  task automatic test_overflow;
    int lat; logic b0;
    convert(24'd16777215, lat, b0);
    n_tot++;
    if ({ifa.seg_value, ifa.range_khz, ifa.ovf} !== {pk(7'h7B, 7'h7B, 7'h7B, 7'h7B), 2'b11})
      $display("FAIL ovf_max got seg=%h rng=%b ovf=%b want seg=%h rng=1 ovf=1",
               ifa.seg_value, ifa.range_khz, ifa.ovf, pk(7'h7B, 7'h7B, 7'h7B, 7'h7B));
    else n_pass++;
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    logic [27:0] got = '0;
    drive_start(24'd1234);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 9) begin
        ifa.freq_bin = 24'd5678; ifb.freq_bin = 24'd5678;
        ifa.start = 1'b1; ifb.start = 1'b1;
      end else if (i == 10) begin
        ifa.start = 1'b0; ifb.start = 1'b0;
      end
      if (ifa.done === 1'b1) begin
        ndone++;
        got = ifa.seg_value;
      end
    end
    n_tot++;
    if (ndone != 1) $display("FAIL busy_start_done_count got %0d want 1", ndone); else n_pass++;
    n_tot++;
    if (got !== pk(7'h30, 7'h6D, 7'h79, 7'h33))
      $display("FAIL busy_start_result got %h want %h", got, pk(7'h30, 7'h6D, 7'h79, 7'h33));
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    wait_done(lat);
    drive_start(24'd1234);
    wait_done(lat);
    // Still inside the done cycle: the FSM is idle, so this start is taken.
    ifa.freq_bin = 24'd5678; ifb.freq_bin = 24'd5678;
    ifa.start = 1'b1; ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 12) begin
        n_tot++;
        if (ifa.seg_value !== pk(7'h30, 7'h6D, 7'h79, 7'h33))
          $display("FAIL b2b_hold got %h want %h", ifa.seg_value, pk(7'h30, 7'h6D, 7'h79, 7'h33));
        else n_pass++;
      end
      if (ifa.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_tot++;
    if (lat != 25) $display("FAIL b2b_latency got %0d want 25", lat); else n_pass++;
    n_tot++;
    if (ifa.seg_value !== pk(7'h5B, 7'h5F, 7'h70, 7'h7F))
      $display("FAIL b2b_seg got %h want %h", ifa.seg_value, pk(7'h5B, 7'h5F, 7'h70, 7'h7F));
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    int lat; logic b0;
    drive_start(24'd1234);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({ifa.seg_value, ifa.busy, ifa.done, ifa.range_khz, ifa.ovf} !== 32'h0)
      $display("FAIL abort_state got seg=%h busy=%b done=%b rng=%b ovf=%b want all 0",
               ifa.seg_value, ifa.busy, ifa.done, ifa.range_khz, ifa.ovf);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) ndone++;
    end
    n_tot++;
    if (ndone != 0) $display("FAIL abort_no_done got %0d want 0", ndone); else n_pass++;
    convert(24'd5678, lat, b0);
    n_tot++;
    if (lat != 25) $display("FAIL post_reset_latency got %0d want 25", lat); else n_pass++;
    n_tot++;
    if (ifa.seg_value !== pk(7'h5B, 7'h5F, 7'h70, 7'h7F))
      $display("FAIL post_reset_seg got %h want %h", ifa.seg_value, pk(7'h5B, 7'h5F, 7'h70, 7'h7F));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hz();
    test_blanking();
    test_khz();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
